// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// one-cycle overflow/underflow pulses, synchronous flush and registered or FWFT read.
module syn_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              almost_full_q, almost_full_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_acc   = wr_req & ~full_q & ~clr;
    rd_acc   = rd_req & ~empty_q & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end
    // Flags follow the next count, so a flush lands them on their reset values.
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_CNT);
    almost_empty_d = (count_d <= AE_CNT);
    almost_full_d  = (count_d >= AF_CNT);
    overflow_d     = wr_req & full_q & ~clr;
    underflow_d    = rd_req & empty_q & ~clr;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  if (FWFT) begin : g_fwft
    assign data_out   = mem[rd_ptr_q];
    assign data_valid = ~empty_q;
  end else begin : g_reg
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;

    always_comb begin
      data_out_d   = data_out_q;
      data_valid_d = rd_acc;
      if (rd_acc) data_out_d = mem[rd_ptr_q];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else begin
        data_out_q   <= data_out_d;
        data_valid_q <= data_valid_d;
      end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
  end

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign fill_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
